traffic_menu_controller: RTL and testbench

- Configuration writer for the traffic light FSM: turns three push-buttons into committed green/yellow/red-hold durations, in seconds.
- Its duration outputs drive the green_duration, yellow_duration and red_holding inputs of the light controller. It also drives menu/edit fields to the 7-segment display mux.
- Committed outputs change only on an explicit commit, so the downstream FSM never sees partial edits.

---
 rtl/traffic_menu_controller.sv | 257 +++++++++++++++++++++++++
 tb/tb_traffic_menu_controller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/traffic_menu_controller.sv
// Three-button menu that edits and commits traffic light durations.
// Optional hold-to-repeat in EDIT: define TRAFFIC_MENU_AUTO_REPEAT_EN.
module traffic_menu_controller #(
  parameter int CLK_FREQ        = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TIMEOUT_SEC     = 10,
  parameter int DEF_GREEN       = 10,
  parameter int DEF_YELLOW      = 3,
  parameter int DEF_RED         = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_select,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [7:0] green_duration,
  output logic [7:0] yellow_duration,
  output logic [7:0] red_holding,
  output logic       menu_active,
  output logic [1:0] edit_field,
  output logic       edit_mode,
  output logic [7:0] edit_value,
  output logic       cfg_update
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] TO_MAX = 32'(TIMEOUT_SEC * CLK_FREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_BROWSE, S_EDIT, S_COMMIT
  } state_t;

  function automatic logic [7:0] fval(
    input logic [1:0] f,
    input logic [7:0] g,
    input logic [7:0] y,
    input logic [7:0] r
  );
    case (f)
      2'd0:    fval = g;
      2'd1:    fval = y;
      default: fval = r;
    endcase
  endfunction

  logic [2:0] raw;
  logic [2:0] sync1_q, sync2_q;
  logic [2:0] level_q, level_d, level_prev_q;
  logic [2:0][DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [2:0] press;

  assign raw   = {btn_down, btn_up, btn_select};
  assign press = level_q & ~level_prev_q;

  always_comb begin
    level_d   = level_q;
    deb_cnt_d = deb_cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (deb_cnt_q[i] == DEB_MAX) begin
          level_d[i]   = sync2_q[i];
          deb_cnt_d[i] = '0;
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end else begin
        deb_cnt_d[i] = '0;
      end
    end
  end

  state_t      state_q, state_d;
  logic [1:0]  field_q, field_d;
  logic [7:0]  shadow_q, shadow_d;
  logic [31:0] to_cnt_q, to_cnt_d;
  logic [7:0]  green_q, green_d;
  logic [7:0]  yellow_q, yellow_d;
  logic [7:0]  red_q, red_d;
  logic        cfg_q, cfg_d;
  logic [7:0]  value_q, value_d;
  logic        rpt_up, rpt_dn;

`ifdef TRAFFIC_MENU_AUTO_REPEAT_EN
  localparam logic [31:0] RPT_FIRST = 32'(CLK_FREQ / 2 - 1);
  localparam logic [31:0] RPT_NEXT  = 32'(CLK_FREQ / 10 - 1);

  logic [31:0] rpt_cnt_q, rpt_cnt_d;
  logic        rpt_on_q, rpt_on_d;
  logic        rpt_first_q, rpt_first_d;
  logic        rpt_btn_q, rpt_btn_d;

  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_on_d    = rpt_on_q;
    rpt_first_d = rpt_first_q;
    rpt_btn_d   = rpt_btn_q;
    rpt_up      = 1'b0;
    rpt_dn      = 1'b0;
    if (state_q != S_EDIT) begin
      rpt_on_d = 1'b0;
    end else if (press[1] || press[2]) begin
      rpt_on_d    = 1'b1;
      rpt_btn_d   = !press[1];
      rpt_cnt_d   = '0;
      rpt_first_d = 1'b1;
    end else if (rpt_on_q) begin
      if (!level_q[rpt_btn_q ? 2 : 1]) begin
        rpt_on_d = 1'b0;
      end else if (rpt_cnt_q == (rpt_first_q ? RPT_FIRST : RPT_NEXT)) begin
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b0;
        rpt_up      = !rpt_btn_q;
        rpt_dn      = rpt_btn_q;
      end else begin
        rpt_cnt_d = rpt_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt_q   <= '0;
      rpt_on_q    <= 1'b0;
      rpt_first_q <= 1'b0;
      rpt_btn_q   <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_on_q    <= rpt_on_d;
      rpt_first_q <= rpt_first_d;
      rpt_btn_q   <= rpt_btn_d;
    end
  end
`else
  assign rpt_up = 1'b0;
  assign rpt_dn = 1'b0;
`endif

  logic       sel_p, up_p, dn_p;
  logic [7:0] fmin;

  assign sel_p = press[0];
  assign up_p  = !sel_p && (press[1] || rpt_up);
  assign dn_p  = !sel_p && !(press[1] || rpt_up) && (press[2] || rpt_dn);
  assign fmin  = (field_q == 2'd2) ? 8'd0 : 8'd1;

  always_comb begin
    state_d  = state_q;
    field_d  = field_q;
    shadow_d = shadow_q;
    to_cnt_d = to_cnt_q + 32'd1;
    green_d  = green_q;
    yellow_d = yellow_q;
    red_d    = red_q;
    cfg_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        to_cnt_d = '0;
        field_d  = 2'd0;
        if (sel_p) state_d = S_BROWSE;
      end
      S_BROWSE: begin
        if (sel_p) begin
          state_d  = S_EDIT;
          shadow_d = fval(field_q, green_q, yellow_q, red_q);
          to_cnt_d = '0;
        end else if (up_p) begin
          field_d  = (field_q == 2'd2) ? 2'd0 : field_q + 2'd1;
          to_cnt_d = '0;
        end else if (dn_p) begin
          field_d  = (field_q == 2'd0) ? 2'd2 : field_q - 2'd1;
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_MAX) begin
          state_d = S_IDLE;
          field_d = 2'd0;
        end
      end
      S_EDIT: begin
        if (sel_p) begin
          state_d = S_COMMIT;
          cfg_d   = 1'b1;
          case (field_q)
            2'd0:    green_d  = shadow_q;
            2'd1:    yellow_d = shadow_q;
            default: red_d    = shadow_q;
          endcase
          to_cnt_d = '0;
        end else if (up_p) begin
          if (shadow_q < 8'd99) shadow_d = shadow_q + 8'd1;
          to_cnt_d = '0;
        end else if (dn_p) begin
          if (shadow_q > fmin) shadow_d = shadow_q - 8'd1;
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_MAX) begin
          state_d = S_IDLE;
          field_d = 2'd0;
        end
      end
      default: begin
        state_d  = S_BROWSE;
        to_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    case (state_d)
      S_IDLE:   value_d = 8'd0;
      S_BROWSE: value_d = fval(field_d, green_d, yellow_d, red_d);
      default:  value_d = shadow_d;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      deb_cnt_q    <= '0;
      state_q      <= S_IDLE;
      field_q      <= 2'd0;
      shadow_q     <= 8'd0;
      to_cnt_q     <= '0;
      green_q      <= 8'(DEF_GREEN);
      yellow_q     <= 8'(DEF_YELLOW);
      red_q        <= 8'(DEF_RED);
      cfg_q        <= 1'b0;
      value_q      <= 8'd0;
    end else begin
      sync1_q      <= raw;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      deb_cnt_q    <= deb_cnt_d;
      state_q      <= state_d;
      field_q      <= field_d;
      shadow_q     <= shadow_d;
      to_cnt_q     <= to_cnt_d;
      green_q      <= green_d;
      yellow_q     <= yellow_d;
      red_q        <= red_d;
      cfg_q        <= cfg_d;
      value_q      <= value_d;
    end
  end

  assign green_duration  = green_q;
  assign yellow_duration = yellow_q;
  assign red_holding     = red_q;
  assign menu_active     = (state_q != S_IDLE);
  assign edit_field      = field_q;
  assign edit_mode       = (state_q == S_EDIT);
  assign edit_value      = value_q;
  assign cfg_update      = cfg_q;

endmodule

// File: tb/tb_traffic_menu_controller.sv
// Directed bench for traffic_menu_controller with small timing parameters.
module tb_traffic_menu_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       bs, bu, bd;
  logic [7:0] g, y, r, ev;
  logic       ma, em, cu;
  logic [1:0] ef;

  int total = 0;
  int bad   = 0;
  int cfg_cnt = 0;
  int exp_cfg = 0;
  bit saw_255 = 0;

  traffic_menu_controller #(
    .CLK_FREQ(1000),
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_SEC(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_select(bs),
    .btn_up(bu),
    .btn_down(bd),
    .green_duration(g),
    .yellow_duration(y),
    .red_holding(r),
    .menu_active(ma),
    .edit_field(ef),
    .edit_mode(em),
    .edit_value(ev),
    .cfg_update(cu)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && cu) cfg_cnt++;
    if (ev == 8'd255) saw_255 = 1;
  end

  typedef struct {
    int         btn;
    logic       ma;
    logic [1:0] ef;
    logic       em;
    logic [7:0] ev;
    logic [7:0] g;
    logic [7:0] y;
    logic [7:0] r;
    int         cfg;
  } vec_t;

  vec_t tv[16];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic press(input int b);
    case (b)
      0: bs = 1'b1;
      1: bu = 1'b1;
      default: bd = 1'b1;
    endcase
    repeat (10) @(negedge clk);
    bs = 1'b0;
    bu = 1'b0;
    bd = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic chk_cfg(input string tag, input int gg, input int yy,
                         input int rr);
    chk({tag, " green"}, int'(g), gg);
    chk({tag, " yellow"}, int'(y), yy);
    chk({tag, " red"}, int'(r), rr);
  endtask

  initial begin
    tv[0]  = '{0, 1, 0, 0, 10, 10, 3, 2, 0};
    tv[1]  = '{0, 1, 0, 1, 10, 10, 3, 2, 0};
    tv[2]  = '{1, 1, 0, 1, 11, 10, 3, 2, 0};
    tv[3]  = '{1, 1, 0, 1, 12, 10, 3, 2, 0};
    tv[4]  = '{1, 1, 0, 1, 13, 10, 3, 2, 0};
    tv[5]  = '{0, 1, 0, 0, 13, 13, 3, 2, 1};
    tv[6]  = '{2, 1, 2, 0, 2, 13, 3, 2, 1};
    tv[7]  = '{0, 1, 2, 1, 2, 13, 3, 2, 1};
    tv[8]  = '{2, 1, 2, 1, 1, 13, 3, 2, 1};
    tv[9]  = '{2, 1, 2, 1, 0, 13, 3, 2, 1};
    tv[10] = '{2, 1, 2, 1, 0, 13, 3, 2, 1};
    tv[11] = '{2, 1, 2, 1, 0, 13, 3, 2, 1};
    tv[12] = '{2, 1, 2, 1, 0, 13, 3, 2, 1};
    tv[13] = '{0, 1, 2, 0, 0, 13, 3, 0, 2};
    tv[14] = '{2, 1, 1, 0, 3, 13, 3, 0, 2};
    tv[15] = '{0, 1, 1, 1, 3, 13, 3, 0, 2};

    rst = 1'b1;
    bs = 1'b0;
    bu = 1'b0;
    bd = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_cfg("reset", 10, 3, 2);
    chk("reset menu_active", int'(ma), 0);
    chk("reset edit_field", int'(ef), 0);
    chk("reset edit_mode", int'(em), 0);
    chk("reset edit_value", int'(ev), 0);
    chk("reset cfg_update", int'(cu), 0);

    repeat (100) @(negedge clk);
    chk("idle cfg pulses", cfg_cnt, 0);
    chk("idle menu_active", int'(ma), 0);
    chk_cfg("idle", 10, 3, 2);

    for (int i = 0; i < 16; i++) begin
      press(tv[i].btn);
      chk($sformatf("v%0d menu_active", i), int'(ma), int'(tv[i].ma));
      chk($sformatf("v%0d edit_field", i), int'(ef), int'(tv[i].ef));
      chk($sformatf("v%0d edit_mode", i), int'(em), int'(tv[i].em));
      chk($sformatf("v%0d edit_value", i), int'(ev), int'(tv[i].ev));
      chk_cfg($sformatf("v%0d", i), tv[i].g, tv[i].y, tv[i].r);
      chk($sformatf("v%0d cfg pulses", i), cfg_cnt, tv[i].cfg);
    end
    exp_cfg = 2;

    for (int i = 0; i < 100; i++) press(1);
    chk("yellow up sat value", int'(ev), 99);
    chk("yellow up sat mode", int'(em), 1);
    chk_cfg("yellow pre-commit", 13, 3, 0);
    press(0);
    exp_cfg++;
    chk_cfg("yellow commit", 13, 99, 0);
    chk("yellow commit pulses", cfg_cnt, exp_cfg);
    press(0);
    press(1);
    chk("yellow again sat", int'(ev), 99);
    press(0);
    exp_cfg++;
    chk_cfg("yellow recommit", 13, 99, 0);
    chk("yellow recommit pulses", cfg_cnt, exp_cfg);
    chk("no wrap to 255", int'(saw_255), 0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_cfg("reset2", 10, 3, 2);
    press(0);
    press(0);
    press(1);
    press(1);
    chk("to edit value", int'(ev), 12);
    repeat (1900) @(negedge clk);
    chk("to before expiry mode", int'(em), 1);
    chk("to before expiry active", int'(ma), 1);
    repeat (200) @(negedge clk);
    chk("to expired active", int'(ma), 0);
    chk("to expired mode", int'(em), 0);
    chk("to expired value", int'(ev), 0);
    chk("to expired green", int'(g), 10);
    chk("to expired pulses", cfg_cnt, exp_cfg);

    for (int i = 0; i < 10; i++) begin
      bs = ~bs;
      repeat (2) @(negedge clk);
    end
    bs = 1'b1;
    repeat (20) @(negedge clk);
    chk("bounce active", int'(ma), 1);
    chk("bounce mode", int'(em), 0);
    chk("bounce field", int'(ef), 0);
    bs = 1'b0;
    repeat (12) @(negedge clk);
    chk("bounce release mode", int'(em), 0);

    press(0);
    press(1);
    press(0);
    exp_cfg++;
    chk("mid green commit", int'(g), 11);
    press(0);
    press(1);
    chk("mid edit value", int'(ev), 12);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_cfg("async reset", 10, 3, 2);
    chk("async reset active", int'(ma), 0);
    chk("async reset value", int'(ev), 0);
    chk("async reset mode", int'(em), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("final pulses", cfg_cnt, exp_cfg);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
